// File: rtl/matmul_seq_ctrl.sv
// Sequencing controller for a 4x4 unsigned matrix multiply: streams in A and B, runs one MAC per cycle, streams out 16 results.
// Optional feature: define MATMUL_SAT_EN to saturate results to RES_W bits instead of truncating.
module matmul_seq_ctrl #(
    parameter int DATA_W = 8,
    parameter int RES_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [RES_W-1:0]  out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              busy
);
    localparam int ACC_W  = 2*DATA_W + 2;
    localparam int PROD_W = 2*DATA_W;

    typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DRAIN} state_t;
    state_t state, state_next;

    logic [DATA_W-1:0] operand [32];
    logic [RES_W-1:0]  result  [16];
    logic [4:0]        load_cnt;
    logic [5:0]        step;
    logic [3:0]        idx;
    logic [ACC_W-1:0]  acc;

    logic [1:0]        i_idx, j_idx, k_idx;
    logic [PROD_W-1:0] prod;
    logic [ACC_W-1:0]  sum;
    logic              in_fire;
    logic              out_fire;

    // step packs {i, j, k} so a single increment walks k innermost, then j, then i
    assign {i_idx, j_idx, k_idx} = step;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign prod = PROD_W'(operand[{1'b0, i_idx, k_idx}]) * PROD_W'(operand[{1'b1, k_idx, j_idx}]);
    assign sum  = acc + ACC_W'(prod);

    function automatic logic [RES_W-1:0] fit(input logic [ACC_W-1:0] x);
`ifdef MATMUL_SAT_EN
        if ((x >> RES_W) != '0)
            return '1;
`endif
        return RES_W'(x);
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = (state == IDLE) || (state == LOAD);
        out_valid  = (state == DRAIN);
        out_last   = (state == DRAIN) && (idx == 4'd15);
        out_data   = (state == DRAIN) ? result[idx] : '0;
        busy       = (state != IDLE);
        case (state)
            IDLE:    if (in_fire) state_next = LOAD;
            LOAD:    if (in_fire && load_cnt == 5'd31) state_next = COMPUTE;
            COMPUTE: if (step == 6'd63) state_next = DRAIN;
            DRAIN:   if (out_fire && idx == 4'd15) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (abort)
            state_next = IDLE;
    end

    // Counters and accumulator; every counter wraps back to zero at the end of its phase
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_cnt <= '0;
            step     <= '0;
            idx      <= '0;
            acc      <= '0;
        end else if (abort) begin
            load_cnt <= '0;
            step     <= '0;
            idx      <= '0;
            acc      <= '0;
        end else begin
            case (state)
                IDLE: if (in_fire) load_cnt <= 5'd1;
                LOAD: begin
                    if (in_fire) begin
                        load_cnt <= load_cnt + 5'd1;
                        if (load_cnt == 5'd31) begin
                            step <= '0;
                            acc  <= '0;
                        end
                    end
                end
                COMPUTE: begin
                    step <= step + 6'd1;
                    acc  <= (k_idx == 2'd3) ? '0 : sum;
                end
                DRAIN: if (out_fire) idx <= idx + 4'd1;
                default: ;
            endcase
        end
    end

    // Operand and result storage need no reset; out_data is gated outside DRAIN
    always_ff @(posedge clk) begin
        if (in_fire && !abort)
            operand[(state == IDLE) ? 5'd0 : load_cnt] <= in_data;
        if (state == COMPUTE && k_idx == 2'd3 && !abort)
            result[{i_idx, j_idx}] <= fit(sum);
    end
endmodule

// File: doc/matmul_seq_ctrl.md
# matmul_seq_ctrl

Sequencing controller for the 4x4 unsigned matrix multiplier. It accepts operands A and B as a byte stream and time-shares one 8x8 multiplier with an accumulator across all 64 multiply-accumulate steps. It then streams the 16 results out. The block sits between the host-side load/unload stream and the multiply datapath, replacing the fully parallel combinational array with a one-MAC-per-cycle schedule.

## Interface
- `DATA_W`, default 8: operand element width, unsigned.
- `RES_W`, default 16: result element width. The internal accumulator is `2*DATA_W+2` bits.
- `clk` input, 1 bit: single clock, rising edge.
- `reset` input, 1 bit: asynchronous, active-low reset.
- `abort` input, 1 bit: synchronous. Returns the block to IDLE from any state.
- `in_valid` input, 1 bit: operand element valid.
- `in_data` input, `DATA_W` bits: operand element.
- `in_ready` output, 1 bit: operand element accepted when `in_valid && in_ready`.
- `out_valid` output, 1 bit: result element valid.
- `out_data` output, `RES_W` bits: result element.
- `out_last` output, 1 bit: high with the 16th result element.
- `out_ready` input, 1 bit: result element consumed when `out_valid && out_ready`.
- `busy` output, 1 bit: high in LOAD, COMPUTE and DRAIN.

## Operation
**States:** IDLE, LOAD, COMPUTE, DRAIN.

**Operand order:** 32 elements, row-major. A[0][0]..A[3][3] occupy indices 0–15, then B[0][0]..B[3][3] occupy indices 16–31.

**State behaviour**
- **IDLE:**
  - `in_ready`=1.
  - The first accepted element is stored at index 0 and the state moves to LOAD with load count 1.
- **LOAD:**
  - `in_ready`=1.
  - Each handshake stores to the current index and increments the count.
  - The handshake on index 31 moves the state to COMPUTE and clears i, j, k and the accumulator.
- **COMPUTE:**
  - `in_ready`=0.
  - Each cycle computes `prod = A[i][k]*B[k][j]` (16 bits, unsigned).
  - For k<3: `acc <= acc + prod`.
  - For k=3: `result[i][j] <= fit(acc + prod)` and `acc <= 0`.
  - Iteration order: k innermost, then j, then i.
  - After the step with i=j=k=3, the state moves to DRAIN with result index 0.
- **DRAIN:**
  - `out_valid`=1 and `out_data=result[idx]`, row-major.
  - `out_last`=1 when idx=15.
  - A handshake increments idx.
  - The handshake with idx=15 moves the state to IDLE.
- **abort:** from any state, moves to IDLE on the next edge, clears all counters and deasserts `out_valid`. Storage contents are don't-care. `abort` has priority over any handshake in the same cycle.

**Arithmetic**
- Maximum sum is 4*255*255 = 260100, which needs 18 bits.
- `fit()` truncates to the low `RES_W` bits unless saturation is compiled in (see Configuration).

**Unused inputs:** `in_valid` outside IDLE/LOAD and `out_ready` outside DRAIN are ignored.

**Reset values:** state=IDLE, `in_ready`=1, `out_valid`=0, `out_last`=0, `out_data`=0, `busy`=0. All counters and `acc` are 0.

## Timing
- **Load:** 32 accepted handshakes; no bubbles are required at full rate.
- **Compute:** exactly 64 cycles.
  - COMPUTE spans the 64 cycles after the edge that accepts element 31.
  - `out_valid` first rises on the edge ending the 64th compute cycle.
- **First result latency:** at full rate, element 0 accepted at edge E0 → first `out_valid` at edge E0+31+64 = E0+95.
- **Drain:** 16 handshakes. With `out_ready` held high, this takes 16 cycles, one result per cycle.
- **Back-pressure:** while `out_valid && !out_ready`, `out_data` and `out_last` hold stable.
- **Next load:** `in_ready` rises on the same edge that completes the idx=15 handshake, so the next load may start the following cycle.
- **Outputs:** all outputs are registered or decoded from registered state; there are no combinational paths from inputs to outputs.
- **Reset mid-operation:** asynchronous assertion forces the reset values immediately. Any partial load or compute is discarded.

## Configuration
- **`MATMUL_SAT_EN` defined:** `fit(x)` = x if x < 2^RES_W, else all-ones. With defaults, 260100 → 0xFFFF.
- **`MATMUL_SAT_EN` undefined:** `fit(x)` = x mod 2^RES_W. With defaults, 260100 → 0xF804.

## Test plan
- **Identity product:** A = 1..16 row-major, B = identity, `out_ready`=1 → `out_data` = 1..16 in order, `out_last` only with 16, first `out_valid` 95 cycles after the first accept.
- **Overflow:** A = B = all 255 → every result is 0xF804 without `MATMUL_SAT_EN` and 0xFFFF with it.
- **Back-pressure:** A = all 1, B = all 2 (every result 8); `out_ready` toggles 1,0,0,1,… → exactly 16 results of 0x0008, values stable while stalled, `in_ready`=0 until the last handshake.
- **Gapped load and ignored input:** `in_valid` with random gaps during load; `in_valid`=1 with junk throughout COMPUTE → junk is ignored and results match a golden model.
- **Reset mid-compute:** `reset` low at compute cycle 30, then a full new load → outputs at reset values immediately, no stale results, and the new results are correct.
- **Abort:** `abort` during DRAIN at idx=5 coincident with `out_ready`=1 → IDLE next cycle, `out_valid`=0, `in_ready`=1, no further results.
